// File: rtl/mul7_pkg.sv
// rtl/mul7_pkg.sv - shared types, constants and mod-7 helper for the MUL7 driver
package mul7_pkg;

  localparam int WORD_W = 32;

  // 2^32 mod 7 is 4, so a carry out of the word adder removes 4, i.e. adds 3
  localparam logic [2:0] WRAP_ADJ = 3'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    ADV  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Sum of two residues already reduced to 0..6
  function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

endpackage

// File: rtl/mod7_residue.sv
// rtl/mod7_residue.sv - serial MSB-first mod-7 residue of a 32-bit word
module mod7_residue
  import mul7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] din,
  output logic              busy,
  output logic [2:0]        res
);

  logic [WORD_W-1:0] shreg;
  logic [5:0]        bit_cnt;
  logic [3:0]        dbl;
  logic [3:0]        nxt;

  // r = (2r + b) mod 7; 2r + b never exceeds 13, so one subtraction suffices
  always_comb begin
    dbl = {res, shreg[WORD_W-1]};
    nxt = (dbl >= 4'd7) ? (dbl - 4'd7) : dbl;
  end

  // Shift one bit per cycle for WORD_W cycles after load; result holds afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      res     <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= 6'(WORD_W);
      res     <= '0;
    end else if (bit_cnt != 6'd0) begin
      shreg   <= {shreg[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - 6'd1;
      res     <= nxt[2:0];
    end
  end

  assign busy = (bit_cnt != 6'd0);

endmodule

// File: rtl/mul7_driver.sv
// rtl/mul7_driver.sv - sequence initiator and checker for the MUL7 detector handshake
module mul7_driver
  import mul7_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] base,
  input  logic [WORD_W-1:0] step,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic [WORD_W-1:0] src,
  output logic              src_valid,
  input  logic              ready,
  input  logic              res,
  input  logic              res_valid,
  output logic              done,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  errors
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] step_q;
  logic [CNT_W-1:0]  remaining;
  logic [2:0]        residue;
  logic [TW-1:0]     tcnt;

  logic              res_load;
  logic              base_busy;
  logic              step_busy;
  logic [2:0]        base_res;
  logic [2:0]        step_res;
  logic [WORD_W:0]   sum;
  logic [2:0]        adv_res;
  logic              expect_hit;

  // Both residue units start on the accepting edge and run side by side
  assign res_load = (state == IDLE) && start;

  mod7_residue u_base_res (
    .clk  (clk),
    .rst  (rst),
    .load (res_load),
    .din  (base),
    .busy (base_busy),
    .res  (base_res)
  );

  mod7_residue u_step_res (
    .clk  (clk),
    .rst  (rst),
    .load (res_load),
    .din  (step),
    .busy (step_busy),
    .res  (step_res)
  );

  // Next word and its residue; a carry out of bit 31 is folded back in as +3
  always_comb begin
    sum        = {1'b0, word} + {1'b0, step_q};
    adv_res    = mod7_add(mod7_add(residue, step_res), sum[WORD_W] ? WRAP_ADJ : 3'd0);
    expect_hit = (residue == 3'd0);
  end

  // Sequencer: prepare residues, then one outstanding word at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      step_q    <= '0;
      remaining <= '0;
      residue   <= '0;
      tcnt      <= '0;
      hits      <= '0;
      errors    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word      <= base;
            step_q    <= step;
            remaining <= count;
            hits      <= '0;
            errors    <= '0;
            state     <= PREP;
          end
        end
        PREP: begin
          if (!base_busy && !step_busy) begin
            residue <= base_res;
            state   <= (remaining == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (ready) begin
            tcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            if (res && !(&hits)) hits <= hits + 1'b1;
            if ((res != expect_hit) && !(&errors)) errors <= errors + 1'b1;
            state <= ADV;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            if (!(&errors)) errors <= errors + 1'b1;
            state <= ADV;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ADV: begin
          word      <= sum[WORD_W-1:0];
          residue   <= adv_res;
          remaining <= remaining - 1'b1;
          state     <= (remaining == CNT_W'(1)) ? DONE : SEND;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign src       = word;
  assign src_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_mul7_driver.sv
// tb/tb_mul7_driver.sv - directed self-checking bench for mul7_driver
module tb_mul7_driver;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [31:0] step;
  logic [15:0] count;
  logic        busy;
  logic [31:0] src;
  logic        src_valid;
  logic        ready;
  logic        res;
  logic        res_valid;
  logic        done;
  logic [15:0] hits;
  logic [15:0] errors;

  int total = 0;
  int bad   = 0;

  int  mode = 0;   // 0 ideal, 1 silent, 2 inverted
  bit  clr  = 0;
  bit  pending;
  bit  acc_next;
  int  wcnt;
  logic [31:0] cur_word;
  logic [31:0] sent_q[$];
  logic [31:0] exp_q[$];

  int sv1, sv2, dn;

  mul7_driver #(.TIMEOUT(64), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .step      (step),
    .count     (count),
    .busy      (busy),
    .src       (src),
    .src_valid (src_valid),
    .ready     (ready),
    .res       (res),
    .res_valid (res_valid),
    .done      (done),
    .hits      (hits),
    .errors    (errors)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Detector model: accepts a word, answers LAT cycles later
  initial begin
    ready = 1'b1; res = 1'b0; res_valid = 1'b0;
    pending = 0; acc_next = 0; wcnt = 0; cur_word = '0;
    forever begin
      @(posedge clk);
      #2;
      res_valid = 1'b0;
      if (clr) begin
        pending = 0; acc_next = 0; ready = 1'b1; clr = 0;
      end else if (acc_next) begin
        acc_next = 0; pending = 1; ready = 1'b0; wcnt = 0;
      end else if (pending) begin
        wcnt++;
        if (wcnt == LAT) begin
          res_valid = 1'b1;
          res = ((cur_word % 7) == 0) ^ (mode == 2);
          pending = 0;
          ready = 1'b1;
        end
      end else if (src_valid && ready) begin
        sent_q.push_back(src);
        cur_word = src;
        if (mode != 1) acc_next = 1;
      end
    end
  end

  task automatic run_seq(input string tag, input logic [31:0] b, input logic [31:0] s,
                         input logic [15:0] c, input int md, input bit poke,
                         output int first_sv, output int second_sv, output int done_at);
    int  n;
    bit  got;
    logic prev_sv;
    mode = md;
    sent_q.delete();
    @(negedge clk);
    base = b; step = s; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0; got = 0; prev_sv = 1'b0;
    first_sv = -1; second_sv = -1; done_at = -1;
    while (n < 3000 && !got) begin
      @(negedge clk);
      n++;
      if (src_valid && !prev_sv) begin
        if (first_sv < 0) first_sv = n;
        else if (second_sv < 0) second_sv = n;
      end
      prev_sv = src_valid;
      if (poke && n == 10) begin
        base = 32'd0; step = 32'd7; count = 16'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1;
        done_at = n;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nwords"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), sent_q[i], exp_q[i]);
  endtask

  initial begin
    int n;
    bit found;
    int dcount;
    rst = 1'b1; start = 1'b0; base = '0; step = '0; count = '0;
    repeat (3) @(negedge clk);
    chk("rst_src", src, 0);
    chk("rst_src_valid", src_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hits", hits, 0);
    chk("rst_errors", errors, 0);
    rst = 1'b0;

    // multiples of 7 from zero
    exp_q = '{32'd0, 32'd7, 32'd14, 32'd21};
    run_seq("t1", 32'd0, 32'd7, 16'd4, 0, 0, sv1, sv2, dn);
    chk("t1_sv_lat", sv1, 33);
    check_words("t1");
    chk("t1_hits", hits, 4);
    chk("t1_errors", errors, 0);

    // 14,15,16 with a start pulse while busy
    exp_q = '{32'd14, 32'd15, 32'd16};
    run_seq("t2", 32'd14, 32'd1, 16'd3, 0, 1, sv1, sv2, dn);
    check_words("t2");
    chk("t2_hits", hits, 1);
    chk("t2_errors", errors, 0);

    // word adder wraps; second word is 3
    exp_q = '{32'hFFFF_FFFC, 32'd3};
    run_seq("t3", 32'hFFFF_FFFC, 32'd7, 16'd2, 0, 0, sv1, sv2, dn);
    check_words("t3");
    chk("t3_hits", hits, 1);
    chk("t3_errors", errors, 0);

    // empty sequence
    exp_q.delete();
    run_seq("t4", 32'd5, 32'd3, 16'd0, 0, 0, sv1, sv2, dn);
    chk("t4_done_lat", dn, 33);
    chk("t4_no_sv", sv1, -1);
    check_words("t4");

    // inverted detector: every verdict wrong, six words report res=1
    exp_q = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13};
    run_seq("t5", 32'd7, 32'd1, 16'd7, 2, 0, sv1, sv2, dn);
    check_words("t5");
    chk("t5_errors", errors, 7);
    chk("t5_hits", hits, 6);

    // reset while waiting on the second word
    mode = 0;
    sent_q.delete();
    @(negedge clk);
    base = 32'd0; step = 32'd7; count = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    n = 0;
    while (n < 500 && !found) begin
      @(negedge clk);
      n++;
      if (hits == 16'd1 && src_valid) found = 1;
    end
    chk("t6_reached_wait", found, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1; clr = 1;
    @(negedge clk);
    chk("t6_src", src, 0);
    chk("t6_src_valid", src_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_hits", hits, 0);
    chk("t6_errors", errors, 0);
    rst = 1'b0;
    dcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("t6_no_done", dcount, 0);

    // silent detector: each word times out
    exp_q = '{32'd0, 32'd7};
    run_seq("t7", 32'd0, 32'd7, 16'd2, 1, 0, sv1, sv2, dn);
    check_words("t7");
    chk("t7_errors", errors, 2);
    chk("t7_hits", hits, 0);
    chk("t7_sv2_lat", sv2, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
